cache_set_array: RTL and testbench
==================================

Name: cache_set_array

Overview:
- N-way set-associative data-cache storage block.
- Holds tag, valid, dirty and 16-byte line data per way per index.
- Performs word reads and byte, half-word or word writes on hit, accepts line refills, and exposes victim line data and dirty status for write-back.
- Sits between the load/store pipeline and the cache miss controller, which drives begin_load / cs_load_en.

Parameters:
- WAYS, 2, number of ways; a power of two, at least 2.
- INDEX_W, 4, index bits: 2^INDEX_W lines per way.
- Line size is fixed at 16 bytes (offset = addr[3:0]); TAG_W = 28 - INDEX_W.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  synchronous, active-high reset.
- cs_addr_in  in  32  byte address: tag = [31:4+INDEX_W], index = [3+INDEX_W:4], word = [3:2].
- cs_wdata_in  in  32  store data, right-aligned for byte and half-word stores.
- cs_ldata_in  in  128  refill line; word i = bits [32i+31:32i].
- cs_byte_en_in  in  2  store size: 00/11 word, 01 byte, 10 half-word.
- cs_read_en  in  1  read request.
- cs_write_en  in  1  write request.
- cs_load_en  in  1  write cs_ldata_in into the victim line.
- begin_load  in  1  refill in progress; high from victim selection through the load.
- cs_rdata_out  out  32  read data, registered.
- cs_wbdata_out  out  128  victim line data for write-back, combinational.
- cs_dirty_out  out  1  dirty status (see Behaviour).
- cs_hit_out  out  1  tag match with valid at the addressed index, combinational.
- cs_ready_out  out  1  operation-complete pulse, registered.

Behaviour:
- Reset (synchronous, active-high):
  - Clears all valid and dirty bits and the replacement state.
  - Clears the victim latch; cs_rdata_out = 0, cs_ready_out = 0.
  - Data and tag RAMs are not reset.
  - Reset during a refill aborts it; no line is written.
- Hit: cs_hit_out = 1 when any way at the index has valid=1 and tag == addr tag. At most one way can match. cs_hit_out is valid every cycle regardless of the enables.
- Priority when several requests are high in one cycle: cs_load_en > cs_write_en > cs_read_en; lower-priority requests that cycle are ignored.
- Read:
  - On a hit with cs_read_en, the next edge loads cs_rdata_out with the addressed word (addr[1:0] ignored) and sets cs_ready_out = 1 for one cycle.
  - On a miss, cs_rdata_out holds and cs_ready_out = 0.
  - 1-cycle latency.
- Write:
  - On a hit with cs_write_en, the next edge updates the line and sets the way's dirty bit; cs_ready_out pulses.
  - Byte store: lane = addr[1:0], data = wdata[7:0].
  - Half-word store: lane = addr[1] (addr[0] ignored), data = wdata[15:0].
  - On a miss: no state change, no ready pulse.
- Victim selection:
  - While begin_load is low, or in the first cycle it is high, the victim is computed combinationally: the lowest-numbered invalid way at the index, else the replacement-policy way.
  - It is latched on the first begin_load cycle and held while begin_load stays high.
  - A load in the first begin_load cycle uses the combinational victim.
- Load (cs_load_en):
  - Writes cs_ldata_in, the addr tag, valid=1 and dirty=0 into the victim at the index.
  - Updates the replacement state and pulses cs_ready_out.
  - Does not require begin_load; without it the combinational victim is used.
- cs_wbdata_out: the victim line's data while begin_load is high, else the hit way's data (0 on a miss).
- cs_dirty_out: victim valid&dirty while begin_load is high, else the hit way's dirty bit (0 on a miss).
- Replacement policy (default): a per-index round-robin pointer, advanced on each load into that index.
- A read in the same cycle as an in-flight load to the same line is ignored because of priority; the controller re-issues it.

Optional Feature:
- Macro CACHE_LRU_EN.
- Defined: replacement is true LRU using per-index, per-way age counters of log2(WAYS) bits.
  - On a read hit, write hit or load, the accessed way is set to age 0 and younger ways are incremented.
  - The victim is the oldest valid way.
  - Reset sets ages to the way number.
- Not defined: round-robin pointer as above; hits do not affect replacement.

Test Plan:
- Reset, then read 0xfff11114 -> cs_hit_out=0, cs_ready_out stays 0, cs_dirty_out=0.
- begin_load=1 and cs_load_en=1 at 0xfff11110 with ldata 128'h0_0_12345678_0 -> next cycle cs_ready_out=1; read 0xfff11114 -> cs_hit_out=1, cs_rdata_out=0x12345678 one cycle later.
- Word write 0x87654321 to 0xfff11118 (byte_en=00) -> cs_ready_out pulses and dirty=1; read 0xfff11118 returns 0x87654321; cs_dirty_out=1 while addressed.
- Byte write 0xAB at 0xfff11115 (byte_en=01) -> read 0xfff11114 returns 0x1234AB78. Half-word write 0xCDEF at 0xfff11116 (byte_en=10) -> returns 0xCDEFAB78.
- Fill all WAYS at index 1 with distinct tags, dirty one way, then begin_load for a new tag selecting that way -> cs_dirty_out=1 and cs_wbdata_out equals that line. After the load, the old tag misses, the new tag hits, and dirty=0.
- Assert rst during begin_load before cs_load_en -> no line is written, all lookups miss, cs_rdata_out=0.

Source files
------------

// File: rtl/cache_set_array.sv
// N-way set-associative data-cache storage: tag/valid/dirty/16-byte line per way, hit-path reads and writes, refill and victim export.
// Define CACHE_LRU_EN for true-LRU replacement; default is a per-index round-robin pointer.
module cache_set_array #(
    parameter int WAYS    = 2,
    parameter int INDEX_W = 4
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [31:0]  cs_addr_in,
    input  logic [31:0]  cs_wdata_in,
    input  logic [127:0] cs_ldata_in,
    input  logic [1:0]   cs_byte_en_in,
    input  logic         cs_read_en,
    input  logic         cs_write_en,
    input  logic         cs_load_en,
    input  logic         begin_load,
    output logic [31:0]  cs_rdata_out,
    output logic [127:0] cs_wbdata_out,
    output logic         cs_dirty_out,
    output logic         cs_hit_out,
    output logic         cs_ready_out
);
    localparam int SETS  = 1 << INDEX_W;
    localparam int WAY_W = $clog2(WAYS);
    localparam int TAG_W = 28 - INDEX_W;

    logic [TAG_W-1:0]   addr_tag;
    logic [INDEX_W-1:0] addr_idx;
    logic [1:0]         addr_word;
    assign addr_tag  = cs_addr_in[31:4+INDEX_W];
    assign addr_idx  = cs_addr_in[3+INDEX_W:4];
    assign addr_word = cs_addr_in[3:2];

    logic [127:0]     data_q  [WAYS][SETS];
    logic [TAG_W-1:0] tag_q   [WAYS][SETS];
    logic [WAYS-1:0]  valid_q [SETS];
    logic [WAYS-1:0]  valid_d [SETS];
    logic [WAYS-1:0]  dirty_q [SETS];
    logic [WAYS-1:0]  dirty_d [SETS];
    logic [WAY_W-1:0] victim_q, victim_d;
    logic             begin_load_q, begin_load_d;
    logic [31:0]      rdata_q, rdata_d;
    logic             ready_q, ready_d;
`ifdef CACHE_LRU_EN
    logic [WAY_W-1:0] age_q [SETS][WAYS];
    logic [WAY_W-1:0] age_d [SETS][WAYS];
`else
    logic [WAY_W-1:0] rr_q [SETS];
    logic [WAY_W-1:0] rr_d [SETS];
`endif

    logic             hit;
    logic [WAY_W-1:0] hit_way, policy_way, victim_comb, victim_sel, line_way, access_way;
    logic [127:0]     hit_line, line_wdata;
    logic [31:0]      word_merged;
    logic             line_we, tag_we, access, found_invalid;

    always_comb begin
        hit     = 1'b0;
        hit_way = '0;
        for (int unsigned w = 0; w < WAYS; w++) begin
            if (valid_q[addr_idx][w] && tag_q[w][addr_idx] == addr_tag) begin
                hit     = 1'b1;
                hit_way = WAY_W'(w);
            end
        end
        hit_line = data_q[hit_way][addr_idx];
    end

    always_comb begin
`ifdef CACHE_LRU_EN
        policy_way = '0;
        for (int unsigned w = 0; w < WAYS; w++) begin
            if (age_q[addr_idx][w] == WAY_W'(WAYS - 1)) policy_way = WAY_W'(w);
        end
`else
        policy_way = rr_q[addr_idx];
`endif
        victim_comb   = policy_way;
        found_invalid = 1'b0;
        for (int unsigned w = 0; w < WAYS; w++) begin
            if (!found_invalid && !valid_q[addr_idx][w]) begin
                victim_comb   = WAY_W'(w);
                found_invalid = 1'b1;
            end
        end
        // After the first begin_load cycle the latched victim is authoritative.
        victim_sel = (begin_load && begin_load_q) ? victim_q : victim_comb;
    end

    always_comb begin
        word_merged = hit_line[{addr_word, 5'b0} +: 32];
        case (cs_byte_en_in)
            2'b01:   word_merged[{cs_addr_in[1:0], 3'b0} +: 8] = cs_wdata_in[7:0];
            2'b10:   word_merged[{cs_addr_in[1], 4'b0} +: 16]  = cs_wdata_in[15:0];
            default: word_merged = cs_wdata_in;
        endcase
    end

    always_comb begin
        valid_d      = valid_q;
        dirty_d      = dirty_q;
        rdata_d      = rdata_q;
        ready_d      = 1'b0;
        begin_load_d = begin_load;
        victim_d     = victim_q;
        line_we      = 1'b0;
        tag_we       = 1'b0;
        line_way     = hit_way;
        line_wdata   = hit_line;
        access       = 1'b0;
        access_way   = hit_way;
        if (begin_load && !begin_load_q) victim_d = victim_comb;

        if (cs_load_en) begin
            line_we    = 1'b1;
            tag_we     = 1'b1;
            line_way   = victim_sel;
            line_wdata = cs_ldata_in;
            valid_d[addr_idx][victim_sel] = 1'b1;
            dirty_d[addr_idx][victim_sel] = 1'b0;
            ready_d    = 1'b1;
            access     = 1'b1;
            access_way = victim_sel;
        end else if (cs_write_en && hit) begin
            line_we = 1'b1;
            line_wdata[{addr_word, 5'b0} +: 32] = word_merged;
            dirty_d[addr_idx][hit_way] = 1'b1;
            ready_d = 1'b1;
            access  = 1'b1;
        end else if (cs_read_en && hit) begin
            rdata_d = hit_line[{addr_word, 5'b0} +: 32];
            ready_d = 1'b1;
            access  = 1'b1;
        end
    end

`ifdef CACHE_LRU_EN
    always_comb begin
        age_d = age_q;
        if (access) begin
            for (int unsigned w = 0; w < WAYS; w++) begin
                if (WAY_W'(w) == access_way)
                    age_d[addr_idx][w] = '0;
                else if (age_q[addr_idx][w] < age_q[addr_idx][access_way])
                    age_d[addr_idx][w] = age_q[addr_idx][w] + WAY_W'(1);
            end
        end
    end
`else
    always_comb begin
        rr_d = rr_q;
        if (cs_load_en) rr_d[addr_idx] = rr_q[addr_idx] + WAY_W'(1);
    end
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            valid_q      <= '{default: '0};
            dirty_q      <= '{default: '0};
            victim_q     <= '0;
            begin_load_q <= 1'b0;
            rdata_q      <= '0;
            ready_q      <= 1'b0;
`ifdef CACHE_LRU_EN
            for (int unsigned s = 0; s < SETS; s++)
                for (int unsigned w = 0; w < WAYS; w++)
                    age_q[s][w] <= WAY_W'(w);
`else
            rr_q <= '{default: '0};
`endif
        end else begin
            valid_q      <= valid_d;
            dirty_q      <= dirty_d;
            victim_q     <= victim_d;
            begin_load_q <= begin_load_d;
            rdata_q      <= rdata_d;
            ready_q      <= ready_d;
`ifdef CACHE_LRU_EN
            age_q <= age_d;
`else
            rr_q <= rr_d;
`endif
        end
    end

    // Line and tag storage are not reset; reset only blocks the write.
    always_ff @(posedge clk) begin
        if (!rst && line_we) data_q[line_way][addr_idx] <= line_wdata;
        if (!rst && tag_we)  tag_q[line_way][addr_idx]  <= addr_tag;
    end

    assign cs_rdata_out  = rdata_q;
    assign cs_ready_out  = ready_q;
    assign cs_hit_out    = hit;
    assign cs_wbdata_out = begin_load ? data_q[victim_sel][addr_idx] : (hit ? hit_line : '0);
    assign cs_dirty_out  = begin_load ? (valid_q[addr_idx][victim_sel] & dirty_q[addr_idx][victim_sel])
                                      : (hit & dirty_q[addr_idx][hit_way]);
endmodule

// File: tb/tb_cache_set_array.sv
// Directed bench for cache_set_array: line model plus read-data scoreboard queue.
module tb_cache_set_array;
    localparam int WAYS    = 2;
    localparam int INDEX_W = 4;

    logic         clk = 1'b0;
    logic         rst;
    logic [31:0]  cs_addr_in;
    logic [31:0]  cs_wdata_in;
    logic [127:0] cs_ldata_in;
    logic [1:0]   cs_byte_en_in;
    logic         cs_read_en, cs_write_en, cs_load_en, begin_load;
    logic [31:0]  cs_rdata_out;
    logic [127:0] cs_wbdata_out;
    logic         cs_dirty_out, cs_hit_out, cs_ready_out;

    cache_set_array #(.WAYS(WAYS), .INDEX_W(INDEX_W)) dut (
        .clk(clk), .rst(rst), .cs_addr_in(cs_addr_in), .cs_wdata_in(cs_wdata_in),
        .cs_ldata_in(cs_ldata_in), .cs_byte_en_in(cs_byte_en_in), .cs_read_en(cs_read_en),
        .cs_write_en(cs_write_en), .cs_load_en(cs_load_en), .begin_load(begin_load),
        .cs_rdata_out(cs_rdata_out), .cs_wbdata_out(cs_wbdata_out), .cs_dirty_out(cs_dirty_out),
        .cs_hit_out(cs_hit_out), .cs_ready_out(cs_ready_out)
    );

    always #5 clk = ~clk;

    int unsigned  total_cnt = 0;
    int unsigned  pass_cnt  = 0;
    logic [31:0]  sb_q[$];
    logic [127:0] mem [logic [27:0]];

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        total_cnt++;
        assert (obs === exp) pass_cnt++;
        else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        cs_read_en = 1'b0; cs_write_en = 1'b0; cs_load_en = 1'b0; begin_load = 1'b0;
        cs_byte_en_in = 2'b00; cs_wdata_in = '0; cs_ldata_in = '0;
    endtask

    task automatic do_read(input logic [31:0] a, input logic exp_hit, input string tag);
        logic [31:0]  prev;
        logic [127:0] line;
        prev = cs_rdata_out;
        cs_addr_in = a; cs_read_en = 1'b1;
        #1;
        check({tag, "_hit"}, cs_hit_out, exp_hit);
        if (exp_hit) begin
            line = mem[a[31:4]];
            sb_q.push_back(line[{a[3:2], 5'b0} +: 32]);
        end
        step();
        cs_read_en = 1'b0;
        check({tag, "_rdy"}, cs_ready_out, exp_hit);
        if (cs_ready_out) begin
            if (sb_q.size() == 0) check({tag, "_sb_empty"}, 1'b1, 1'b0);
            else check({tag, "_data"}, cs_rdata_out, sb_q.pop_front());
        end else begin
            check({tag, "_hold"}, cs_rdata_out, prev);
        end
    endtask

    task automatic do_write(input logic [31:0] a, input logic [31:0] d, input logic [1:0] be,
                            input logic exp_hit, input string tag);
        logic [127:0] line;
        logic [31:0]  word;
        cs_addr_in = a; cs_wdata_in = d; cs_byte_en_in = be; cs_write_en = 1'b1;
        #1;
        check({tag, "_hit"}, cs_hit_out, exp_hit);
        step();
        cs_write_en = 1'b0;
        check({tag, "_rdy"}, cs_ready_out, exp_hit);
        if (exp_hit) begin
            line = mem[a[31:4]];
            word = line[{a[3:2], 5'b0} +: 32];
            case (be)
                2'b01:   word[{a[1:0], 3'b0} +: 8] = d[7:0];
                2'b10:   word[{a[1], 4'b0} +: 16]  = d[15:0];
                default: word = d;
            endcase
            line[{a[3:2], 5'b0} +: 32] = word;
            mem[a[31:4]] = line;
        end
    endtask

    task automatic do_load(input logic [31:0] a, input logic [127:0] ld, input logic bl, input string tag);
        cs_addr_in = a; cs_ldata_in = ld; cs_load_en = 1'b1; begin_load = bl;
        step();
        cs_load_en = 1'b0; begin_load = 1'b0;
        check({tag, "_rdy"}, cs_ready_out, 1'b1);
        mem[a[31:4]] = ld;
    endtask

    task automatic peek(input logic [31:0] a, input logic exp_hit, input logic exp_dirty, input string tag);
        cs_addr_in = a;
        #1;
        check({tag, "_hit"}, cs_hit_out, exp_hit);
        check({tag, "_dirty"}, cs_dirty_out, exp_dirty);
    endtask

    localparam logic [31:0] A = 32'hfff1_1110;
    localparam logic [31:0] B = 32'h0000_0010;
    localparam logic [31:0] C = 32'h0000_0110;
    localparam logic [31:0] D = 32'h0000_0220;

    initial begin
        idle();
        cs_addr_in = '0;
        rst = 1'b1;
        step(); step();
        rst = 1'b0;
        check("rst_rdata", cs_rdata_out, 32'h0);
        check("rst_ready", cs_ready_out, 1'b0);

        peek(32'hfff1_1114, 1'b0, 1'b0, "cold");
        do_read(32'hfff1_1114, 1'b0, "cold_rd");

        do_load(A, 128'h0000_0000_0000_0000_1234_5678_0000_0000, 1'b1, "load_a");
        do_read(32'hfff1_1114, 1'b1, "rd_a1");

        do_write(32'hfff1_1118, 32'h8765_4321, 2'b00, 1'b1, "wr_word");
        peek(32'hfff1_1118, 1'b1, 1'b1, "a_dirty");
        do_read(32'hfff1_1118, 1'b1, "rd_a2");

        do_write(32'hfff1_1115, 32'h0000_00ab, 2'b01, 1'b1, "wr_byte");
        do_read(32'hfff1_1114, 1'b1, "rd_byte");
        check("byte_lit", cs_rdata_out, 32'h1234_ab78);
        do_write(32'hfff1_1116, 32'h0000_cdef, 2'b10, 1'b1, "wr_half");
        do_read(32'hfff1_1114, 1'b1, "rd_half");
        check("half_lit", cs_rdata_out, 32'hcdef_ab78);

        do_write(32'h0000_0334, 32'hdead_beef, 2'b00, 1'b0, "wr_miss");

        do_load(B, 128'hbbbb_0003_bbbb_0002_bbbb_0001_bbbb_0000, 1'b0, "load_b");
        peek(B, 1'b1, 1'b0, "b_clean");

        // Index 1 is full; the dirty line A is the round-robin victim.
        cs_addr_in = C; begin_load = 1'b1;
        #1;
        check("vic_dirty", cs_dirty_out, 1'b1);
        check("vic_wb", cs_wbdata_out, mem[A[31:4]]);
        step();
        cs_addr_in = B;
        #1;
        check("vic_hold_wb", cs_wbdata_out, mem[A[31:4]]);
        cs_addr_in = C;
        do_load(C, 128'hcccc_0003_cccc_0002_cccc_0001_cccc_0000, 1'b1, "load_c");
        mem.delete(A[31:4]);
        peek(A, 1'b0, 1'b0, "a_evicted");
        peek(C, 1'b1, 1'b0, "c_clean");
        do_read(C + 32'h8, 1'b1, "rd_c");
        do_read(B + 32'h4, 1'b1, "rd_b");

        // Write outranks a simultaneous read: one pulse, read data untouched.
        cs_read_en = 1'b1;
        do_write(C, 32'h55aa_55aa, 2'b00, 1'b1, "wr_prio");
        check("prio_rdata", cs_rdata_out, 32'hbbbb_0001);
        do_read(C, 1'b1, "rd_prio");

        cs_addr_in = D; begin_load = 1'b1;
        step();
        rst = 1'b1; cs_load_en = 1'b1; cs_ldata_in = {4{32'h1111_2222}};
        step();
        rst = 1'b0;
        idle();
        check("abort_ready", cs_ready_out, 1'b0);
        check("abort_rdata", cs_rdata_out, 32'h0);
        peek(D, 1'b0, 1'b0, "abort_d");
        peek(C, 1'b0, 1'b0, "abort_c");
        peek(B, 1'b0, 1'b0, "abort_b");
        check("sb_drained", sb_q.size(), 0);

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end
endmodule
